hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/hazard_scoreboard_if.sv | 37 +++
 rtl/hazard_scoreboard_load_age_pipe.sv | 55 +++++
 rtl/hazard_scoreboard.sv | 109 ++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared FSM encoding and parameter defaults for the hazard
//               scoreboard.
// Revision    : 1.0  initial release
// ============================================================================
package hazard_pkg;

    localparam int DEF_RW       = 5;
    localparam int DEF_LOAD_LAT = 1;
    localparam int DEF_BR_STALL = 2;
    localparam int DEF_CW       = 16;

    localparam int BR_CNT_W     = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LD_STALL = 2'd1,
        BR_WAIT  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_if
// Description : IF/ID decode inputs and stall-control outputs of the hazard
//               scoreboard, bundled with master (pipeline) / slave (unit) views.
// Revision    : 1.0  initial release
// ============================================================================
interface hazard_scoreboard_if #(
    parameter int RW = 5,
    parameter int CW = 16
);
    logic          ifid_valid;
    logic [RW-1:0] ifid_rs;
    logic [RW-1:0] ifid_rt;
    logic          ifid_uses_rt;
    logic          ifid_memread;
    logic [RW-1:0] ifid_dest;
    logic          ifid_branch;
    logic          pc_stall;
    logic          ifid_stall;
    logic          idex_bubble;
    logic [1:0]    state_o;
    logic [CW-1:0] stall_cnt;

    modport master (
        output ifid_valid, ifid_rs, ifid_rt, ifid_uses_rt,
               ifid_memread, ifid_dest, ifid_branch,
        input  pc_stall, ifid_stall, idex_bubble, state_o, stall_cnt
    );

    modport slave (
        input  ifid_valid, ifid_rs, ifid_rt, ifid_uses_rt,
               ifid_memread, ifid_dest, ifid_branch,
        output pc_stall, ifid_stall, idex_bubble, state_o, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard_load_age_pipe.sv
`default_nettype none
// ============================================================================
// Module      : load_age_pipe
// Description : Shift register of in-flight load destinations plus source
//               comparators producing a single load-use hazard bit.
// Revision    : 1.0  initial release
// ============================================================================
module load_age_pipe
    import hazard_pkg::*;
#(
    parameter int RW       = DEF_RW,
    parameter int LOAD_LAT = DEF_LOAD_LAT
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          i_push,
    input  wire logic [RW-1:0] i_dest,
    input  wire logic          i_valid,
    input  wire logic [RW-1:0] i_rs,
    input  wire logic [RW-1:0] i_rt,
    input  wire logic          i_uses_rt,
    output logic               o_hazard
);

    logic [LOAD_LAT-1:0] r_vld;
    logic [RW-1:0]       r_dst [LOAD_LAT];
    logic [LOAD_LAT-1:0] w_hit;

    // Slot k holds a load issued k+1 cycles ago; shifting never pauses, so
    // stalled cycles naturally enter as invalid slots.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= i_push;
            r_dst[0] <= i_dest;
            for (int k = 1; k < LOAD_LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_dst[k] <= r_dst[k-1];
            end
        end
    end

    generate
        for (genvar k = 0; k < LOAD_LAT; k++) begin : g_cmp
            assign w_hit[k] = r_vld[k] &&
                              (((i_rs != '0) && (r_dst[k] == i_rs)) ||
                               (i_uses_rt && (i_rt != '0) && (r_dst[k] == i_rt)));
        end
    endgenerate

    assign o_hazard = i_valid && (|w_hit);

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Load-use and branch stall controller for a 5-stage pipeline,
//               with a saturating stall-cycle counter.
// Revision    : 1.0  initial release
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int RW       = DEF_RW,
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int BR_STALL = DEF_BR_STALL,
    parameter int CW       = DEF_CW
) (
    input  wire logic           clk,
    input  wire logic           reset,
    hazard_scoreboard_if.slave  bus
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [BR_CNT_W-1:0]   r_br_cnt;
    logic [BR_CNT_W-1:0]   w_br_cnt_nxt;
    logic [CW-1:0]         r_stall_cnt;
    logic                  w_hazard;
    logic                  w_stall;
    logic                  w_issue;
    logic                  w_push;

    assign w_issue = bus.ifid_valid && !w_stall;
    assign w_push  = w_issue && bus.ifid_memread && (bus.ifid_dest != '0);

    load_age_pipe #(
        .RW       (RW),
        .LOAD_LAT (LOAD_LAT)
    ) u_age (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push),
        .i_dest    (bus.ifid_dest),
        .i_valid   (bus.ifid_valid),
        .i_rs      (bus.ifid_rs),
        .i_rt      (bus.ifid_rt),
        .i_uses_rt (bus.ifid_uses_rt),
        .o_hazard  (w_hazard)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_br_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_br_cnt <= w_br_cnt_nxt;
        end
    end

    // Once a load stall clears, that same cycle behaves as IDLE, so a branch
    // that was waiting on the load can issue and go straight to BR_WAIT.
    always_comb begin
        w_state_nxt  = r_state;
        w_br_cnt_nxt = r_br_cnt;
        w_stall      = 1'b0;
        case (r_state)
            IDLE, LD_STALL: begin
                if (w_hazard) begin
                    w_stall     = 1'b1;
                    w_state_nxt = LD_STALL;
                end else begin
                    w_state_nxt = IDLE;
                    if (bus.ifid_valid && bus.ifid_branch && (BR_STALL > 0)) begin
                        w_state_nxt  = BR_WAIT;
                        w_br_cnt_nxt = BR_CNT_W'(BR_STALL);
                    end
                end
            end
            BR_WAIT: begin
                w_stall = 1'b1;
                if (r_br_cnt <= BR_CNT_W'(1)) begin
                    w_state_nxt  = IDLE;
                    w_br_cnt_nxt = '0;
                end else begin
                    w_br_cnt_nxt = r_br_cnt - BR_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_br_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CW{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CW'(1);
        end
    end

    assign bus.pc_stall    = w_stall;
    assign bus.ifid_stall  = w_stall;
    assign bus.idex_bubble = w_stall;
    assign bus.state_o     = r_state;
    assign bus.stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire
